// File: rtl/wb_stage.sv
// wb_stage: write-back stage of the WISC pipeline.
// Holds the MEM/WB register, owns the register file with bypassed decode reads,
// drives forwarding info, latches a sticky halted flag and counts retirements.
module wb_stage #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_valid,
  input  logic [DATA_W-1:0] mem_rd_data,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              mem_to_reg,
  input  logic              reg_wr_en,
  input  logic [REG_AW-1:0] wr_reg,
  input  logic              halt_in,
  input  logic              stall,
  input  logic              flush,
  input  logic [REG_AW-1:0] rd_reg1,
  input  logic [REG_AW-1:0] rd_reg2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic              fwd_valid,
  output logic [REG_AW-1:0] fwd_reg,
  output logic [DATA_W-1:0] fwd_data,
  output logic              halted,
  output logic [15:0]       retired_count
);

  localparam int NREGS = 2 ** REG_AW;

  logic              wb_valid;
  logic [DATA_W-1:0] wb_data;
  logic              wb_wr_en;
  logic [REG_AW-1:0] wb_reg;
  logic              wb_halt;

  logic [DATA_W-1:0] regfile [NREGS];

  logic [DATA_W-1:0] wb_sel_data;
  logic              wb_write;

  // Write-back value is muxed before capture so WB only carries one data field
  always_comb begin
    wb_sel_data = mem_to_reg ? mem_rd_data : alu_result;
  end

  // MEM/WB register: halted or flush load a bubble, stall holds, else capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid <= 1'b0;
      wb_data  <= '0;
      wb_wr_en <= 1'b0;
      wb_reg   <= '0;
      wb_halt  <= 1'b0;
    end else if (halted || flush) begin
      wb_valid <= 1'b0;
      wb_data  <= '0;
      wb_wr_en <= 1'b0;
      wb_reg   <= '0;
      wb_halt  <= 1'b0;
    end else if (!stall) begin
      wb_valid <= mem_valid;
      wb_data  <= wb_sel_data;
      wb_wr_en <= reg_wr_en;
      wb_reg   <= wr_reg;
      wb_halt  <= halt_in;
    end
  end

  // A register write happens exactly when forwarding is advertised
  always_comb begin
    wb_write  = wb_valid && wb_wr_en && !wb_halt && !halted;
    fwd_valid = wb_write;
    fwd_reg   = wb_reg;
    fwd_data  = wb_data;
  end

  // Register file: single write port, R0 is an ordinary register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regfile[i] <= '0;
      end
    end else if (wb_write) begin
      regfile[wb_reg] <= wb_data;
    end
  end

  // Decode read ports, each bypassing the in-flight write independently
  always_comb begin
    rd_data1 = (fwd_valid && (rd_reg1 == fwd_reg)) ? fwd_data : regfile[rd_reg1];
    rd_data2 = (fwd_valid && (rd_reg2 == fwd_reg)) ? fwd_data : regfile[rd_reg2];
  end

  // Sticky halt flag, set when a HALT reaches WB
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      halted <= 1'b0;
    end else if (wb_valid && wb_halt && !halted) begin
      halted <= 1'b1;
    end
  end

  // Retired instruction counter (HALT itself counts), free-running wrap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retired_count <= '0;
    end else if (wb_valid && !halted) begin
      retired_count <= retired_count + 16'd1;
    end
  end

endmodule
